// File: rtl/conv_pkg.sv
// Shared sizing, derived counter widths and state encoding for the CONV sequencer.
package conv_pkg;

    localparam int DATA_W  = 3;
    localparam int SIG_LEN = 8;
    localparam int KER_LEN = 3;
    localparam int OUT_W   = 8;
    localparam int OUT_LEN = SIG_LEN - KER_LEN + 1;

    localparam int IDX_W = $clog2(SIG_LEN);
    localparam int K_W   = $clog2(KER_LEN);
    localparam int W_W   = $clog2(OUT_LEN);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIG_LEN - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(KER_LEN - 1);
    localparam logic [W_W-1:0]   W_LAST   = W_W'(OUT_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, SEND} state_t;

    // Signal sample feeding tap k of window w.
    function automatic logic [IDX_W-1:0] sig_index(logic [W_W-1:0] w, logic [K_W-1:0] k);
        return IDX_W'(w) + IDX_W'(k);
    endfunction

endpackage

// File: rtl/conv_if.sv
// Frame input beats, shared-MAC control and CDC sender handshake of the CONV sequencer.
interface conv_if
    import conv_pkg::*;
();
    logic              in_valid;
    logic [DATA_W-1:0] in_data1;
    logic [DATA_W-1:0] in_data2;
    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [OUT_W-1:0]  mac_acc;
    logic              tx_valid;
    logic [OUT_W-1:0]  tx_data;
    logic              tx_busy;

    modport master (
        input  in_valid, in_data1, in_data2, mac_acc, tx_busy,
        output mac_clr, mac_en, mac_a, mac_b, tx_valid, tx_data
    );

    modport slave (
        output in_valid, in_data1, in_data2, mac_acc, tx_busy,
        input  mac_clr, mac_en, mac_a, mac_b, tx_valid, tx_data
    );
endinterface

// File: rtl/conv_frame_buf.sv
// Per-frame register file: signal samples and kernel taps, one write port, two
// combinational read ports.
module conv_frame_buf
    import conv_pkg::*;
(
    input  logic              clk_1,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_sig,
    input  logic [DATA_W-1:0] wr_ker,
    input  logic [IDX_W-1:0]  sig_idx,
    input  logic [K_W-1:0]    ker_idx,
    output logic [DATA_W-1:0] sig_rd,
    output logic [DATA_W-1:0] ker_rd
);
    logic [DATA_W-1:0] sig_mem [SIG_LEN];
    logic [DATA_W-1:0] ker_mem [KER_LEN];

    always_ff @(posedge clk_1) begin
        if (rst) begin
            for (int i = 0; i < SIG_LEN; i++) sig_mem[i] <= '0;
            for (int i = 0; i < KER_LEN; i++) ker_mem[i] <= '0;
        end else if (we) begin
            sig_mem[wr_idx] <= wr_sig;
            // Only the first KER_LEN beats carry kernel taps.
            if (wr_idx < IDX_W'(KER_LEN)) ker_mem[wr_idx[K_W-1:0]] <= wr_ker;
        end
    end

    assign sig_rd = sig_mem[sig_idx];
    assign ker_rd = ker_mem[ker_idx];
endmodule

// File: rtl/conv_sched.sv
// CONV sequencer: loads a frame, drives the shared MAC one window at a time and
// pushes each result to the CDC sender.
module conv_sched
    import conv_pkg::*;
(
    input  logic   clk_1,
    input  logic   rst,
    conv_if.master bus,
    output logic   busy,
    output logic   done,
    output logic   frame_err,
    output state_t state
);
    // tx handshake: tx_valid is a one-cycle push, issued only from SEND while
    // tx_busy is low; tx_data is held until the next push.
    state_t            state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [W_W-1:0]    w, w_nx;
    logic [K_W-1:0]    k, k_nx;
    logic              err_nx;
    logic              buf_we;
    logic              op_on;
    logic              mac_en, mac_clr, tx_valid;
    logic [OUT_W-1:0]  tx_data_q;
    logic [DATA_W-1:0] sig_rd, ker_rd;

    conv_frame_buf u_buf (
        .clk_1   (clk_1),
        .rst     (rst),
        .we      (buf_we),
        .wr_idx  (idx),
        .wr_sig  (bus.in_data1),
        .wr_ker  (bus.in_data2),
        .sig_idx (sig_index(w, k)),
        .ker_idx (k),
        .sig_rd  (sig_rd),
        .ker_rd  (ker_rd)
    );

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            w         <= '0;
            k         <= '0;
            frame_err <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            w         <= w_nx;
            k         <= k_nx;
            frame_err <= err_nx;
            if (tx_valid) tx_data_q <= bus.mac_acc;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        w_nx     = w;
        k_nx     = k;
        err_nx   = 1'b0;
        buf_we   = 1'b0;
        op_on    = 1'b0;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        tx_valid = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_we   = 1'b1;
                    idx_nx   = IDX_W'(1);
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    buf_we = 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_nx   = '0;
                        w_nx     = '0;
                        k_nx     = '0;
                        state_nx = COMPUTE;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end else begin
                    err_nx   = 1'b1;
                    idx_nx   = '0;
                    state_nx = IDLE;
                end
            end
            COMPUTE: begin
                op_on   = 1'b1;
                mac_en  = 1'b1;
                mac_clr = (k == '0);
                err_nx  = bus.in_valid;
                if (k == K_LAST) state_nx = SEND;
                else             k_nx     = k + K_W'(1);
            end
            SEND: begin
                // Operands stay on the last tap while waiting for the sender.
                op_on  = 1'b1;
                err_nx = bus.in_valid;
                if (!bus.tx_busy) begin
                    tx_valid = 1'b1;
                    k_nx     = '0;
                    if (w == W_LAST) begin
                        done     = 1'b1;
                        w_nx     = '0;
                        state_nx = IDLE;
                    end else begin
                        w_nx     = w + W_W'(1);
                        state_nx = COMPUTE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign bus.mac_en   = mac_en;
    assign bus.mac_clr  = mac_clr;
    assign bus.mac_a    = op_on ? sig_rd : '0;
    assign bus.mac_b    = op_on ? ker_rd : '0;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_valid ? bus.mac_acc : tx_data_q;
endmodule

// File: tb/tb_conv_sched.sv
// Randomized scoreboard bench for conv_sched with behavioural MAC and CDC-sender models.
module tb_conv_sched;
    import conv_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   busy, done, frame_err;
    state_t state;
    int     cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_if bus();

    conv_sched dut (
        .clk_1     (clk),
        .rst       (rst),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .state     (state)
    );

    // ---------------- environment models ----------------
    int busy_cnt = 0;
    int busy_len = 0;
    int long_at  = -1;
    int long_len = 10;
    int tx_total = 0;

    always @(posedge clk) begin
        if (rst) bus.mac_acc <= '0;
        else if (bus.mac_en)
            bus.mac_acc <= (bus.mac_clr ? OUT_W'(0) : bus.mac_acc)
                           + OUT_W'(bus.mac_a) * OUT_W'(bus.mac_b);
    end

    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (bus.tx_valid) begin
            busy_cnt <= (tx_total == long_at) ? long_len : busy_len;
            tx_total <= tx_total + 1;
        end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [OUT_W:0] exp_q[$];
    int got_t_q[$];
    int mac_cnt = 0;
    int err_cnt = 0;
    logic [DATA_W-1:0] sig_a [SIG_LEN];
    logic [DATA_W-1:0] ker_a [KER_LEN];
    int last_t = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: valid convolution straight from the frame arrays.
    function automatic int model(int w);
        int s = 0;
        for (int k = 0; k < KER_LEN; k++) s += int'(sig_a[w + k]) * int'(ker_a[k]);
        return s;
    endfunction

    initial begin : monitor
        logic           prev_tx = 1'b0;
        logic [OUT_W-1:0] last_tx = '0;
        logic [OUT_W:0] e;
        forever begin
            @(negedge clk);
            if (bus.mac_en) mac_cnt++;
            if (frame_err) err_cnt++;
            if (bus.tx_valid) begin
                got_t_q.push_back(cyc);
                if (prev_tx) fail_now("tx_back_to_back");
                if (exp_q.size() == 0) fail_now("tx_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(bus.tx_data), 32'(e[OUT_W-1:0]));
                    chk("done_with_tx", 32'(done), 32'(e[OUT_W]));
                end
                last_tx = bus.tx_data;
            end else begin
                if (done) fail_now("done_without_tx");
                chk("tx_data_hold", 32'(bus.tx_data), 32'(last_tx));
            end
            prev_tx = bus.tx_valid;
            if (rst) last_tx = '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input int nbeats, input int nexp);
        for (int i = 0; i < nexp; i++) begin
            logic [OUT_W:0] e;
            e[OUT_W-1:0] = OUT_W'(model(i));
            e[OUT_W]     = (i == OUT_LEN - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data1 = sig_a[i];
            bus.in_data2 = (i < KER_LEN) ? ker_a[i] : DATA_W'($urandom);
            last_t = cyc;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data1 = DATA_W'($urandom);
        bus.in_data2 = DATA_W'($urandom);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < SIG_LEN; i++) sig_a[i] = DATA_W'((i + 1) % SIG_LEN);
        for (int i = 0; i < KER_LEN; i++) ker_a[i] = DATA_W'(1);
    endtask

    task automatic load_random();
        for (int i = 0; i < SIG_LEN; i++) sig_a[i] = DATA_W'($urandom_range(0, 7));
        for (int i = 0; i < KER_LEN; i++) ker_a[i] = DATA_W'($urandom_range(0, 7));
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int m0, e0, t, t_low;
        bus.in_valid = 1'b0;
        bus.in_data1 = '0;
        bus.in_data2 = '0;

        // Reset held with in_valid toggling.
        repeat (2) begin
            @(posedge clk); #1;
            bus.in_valid = ~bus.in_valid;
            bus.in_data1 = DATA_W'($urandom);
            bus.in_data2 = DATA_W'($urandom);
        end
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mac_en", 32'(bus.mac_en), 0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_state", 32'(state), 32'(IDLE));
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_frame_err", 32'(frame_err), 0);
        chk("idle_tx_data", 32'(bus.tx_data), 0);
        chk("idle_mac_a", 32'(bus.mac_a), 0);
        chk("rst_mac_count", 32'(mac_cnt), 0);

        // Ramp frame, no backpressure: fixed schedule.
        load_ramp();
        got_t_q.delete();
        m0 = mac_cnt;
        send_frame(SIG_LEN, OUT_LEN);
        t = last_t;
        drain();
        chk("ramp_tx_count", 32'(got_t_q.size()), OUT_LEN);
        for (int i = 0; i < got_t_q.size() && i < OUT_LEN; i++)
            chk("ramp_tx_time", 32'(got_t_q[i] - t), 32'(4 + 4 * i));
        chk("ramp_mac_cycles", 32'(mac_cnt - m0), 32'(OUT_LEN * KER_LEN));

        // Maximum operands: 147 per window, no wrap.
        for (int i = 0; i < SIG_LEN; i++) sig_a[i] = 3'd7;
        for (int i = 0; i < KER_LEN; i++) ker_a[i] = 3'd7;
        send_frame(SIG_LEN, OUT_LEN);
        drain();

        // Sender busy for 10 cycles after the first push.
        load_ramp();
        got_t_q.delete();
        m0 = mac_cnt;
        long_at = tx_total;
        send_frame(SIG_LEN, OUT_LEN);
        t = last_t;
        drain();
        long_at = -1;
        chk("bp_tx_count", 32'(got_t_q.size()), OUT_LEN);
        if (got_t_q.size() == OUT_LEN) begin
            chk("bp_tx0_time", 32'(got_t_q[0] - t), 4);
            chk("bp_tx1_time", 32'(got_t_q[1] - t), 15);
            chk("bp_tx5_time", 32'(got_t_q[5] - t), 31);
        end
        chk("bp_mac_cycles", 32'(mac_cnt - m0), 32'(OUT_LEN * KER_LEN));

        // Frame cut short after 5 beats.
        load_random();
        got_t_q.delete();
        m0 = mac_cnt;
        e0 = err_cnt;
        send_frame(5, 0);
        t_low = cyc;
        wait_until(t_low + 1);
        @(negedge clk);
        chk("abort_frame_err", 32'(frame_err), 1);
        chk("abort_busy", 32'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_err_pulses", 32'(err_cnt - e0), 1);
        chk("abort_mac_cycles", 32'(mac_cnt - m0), 0);
        chk("abort_tx_count", 32'(got_t_q.size()), 0);
        load_ramp();
        send_frame(SIG_LEN, OUT_LEN);
        drain();

        // Reset during window 1 compute.
        load_ramp();
        got_t_q.delete();
        send_frame(SIG_LEN, 1);
        t = last_t;
        wait_until(t + 6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mac_en", 32'(bus.mac_en), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_tx_data", 32'(bus.tx_data), 0);
        chk("midrst_state", 32'(state), 32'(IDLE));
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_tx_count", 32'(got_t_q.size()), 1);
        chk("midrst_exp_left", 32'(exp_q.size()), 0);
        send_frame(SIG_LEN, OUT_LEN);
        drain();

        // Stray beat during compute: error pulse, schedule untouched.
        load_random();
        got_t_q.delete();
        e0 = err_cnt;
        send_frame(SIG_LEN, OUT_LEN);
        t = last_t;
        wait_until(t + 2);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();
        chk("stray_err_pulses", 32'(err_cnt - e0), 1);
        chk("stray_tx_count", 32'(got_t_q.size()), OUT_LEN);
        if (got_t_q.size() == OUT_LEN) chk("stray_last_time", 32'(got_t_q[5] - t), 24);

        // Random frames with random sender latency.
        for (int f = 0; f < 6; f++) begin
            busy_len = $urandom_range(0, 6);
            load_random();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            m0 = mac_cnt;
            send_frame(SIG_LEN, OUT_LEN);
            drain();
            chk("rand_mac_cycles", 32'(mac_cnt - m0), 32'(OUT_LEN * KER_LEN));
        end
        busy_len = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
